dma_disk_ctrl: RTL

Memory-mapped DMA engine that copies blocks of 32-bit words from the disk model into main memory (0x0000_0000–0x0000_7FFF). It sits directly upstream of the main-memory write port. It is programmed by the CPU through the DMA register window at 0x8000_0000–0x8000_000C and raises a done flag when the copy completes.

---
 rtl/dma_disk_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_disk_ctrl.sv
// -----------------------------------------------------------------------------
// dma_disk_ctrl
//
// Memory-mapped DMA engine that copies a block of 32-bit words from the disk
// model into main memory. The CPU programs the source address, destination
// address and byte count through a four-register window, then writes
// INIT_TRAN to start. Only one request (disk read or memory write) is ever
// outstanding. A sticky done flag reports completion.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   reg_addr/wr/rd      CPU register access (one-cycle strobes)
//   reg_wdata           CPU write data
//   reg_rdata           registered read data, valid the cycle after reg_rd
//   disk_rd_req         disk read request, held until disk_rd_ack
//   disk_addr           disk byte address (word aligned)
//   disk_rd_ack/data    disk data valid pulse and data
//   mem_wr_req          memory write request, held until mem_wr_ack
//   mem_addr/wdata      memory byte address (word aligned) and data
//   mem_wr_ack          memory write accepted pulse
//   dma_busy            transfer in progress
//   dma_done            sticky completion flag
// -----------------------------------------------------------------------------
module dma_disk_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int DISK_AW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        reg_addr,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               disk_rd_req,
    output logic [DISK_AW-1:0] disk_addr,
    input  logic               disk_rd_ack,
    input  logic [31:0]        disk_rd_data,
    output logic               mem_wr_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_wr_ack,
    output logic               dma_busy,
    output logic               dma_done
);

    localparam logic [31:0] A_DISK_ADDR = 32'h8000_0000;
    localparam logic [31:0] A_MEM_ADDR  = 32'h8000_0004;
    localparam logic [31:0] A_T_SIZE    = 32'h8000_0008;
    localparam logic [31:0] A_INIT_TRAN = 32'h8000_000C;

    localparam logic [DISK_AW-1:0] DISK_STEP = DISK_AW'(4);
    localparam logic [ADDR_W-1:0]  MEM_STEP  = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    // Programmed (CPU-visible) registers
    logic [DISK_AW-1:0]  disk_addr_reg_r;
    logic [ADDR_W-1:0]   mem_addr_reg_r;
    logic [31:0]         t_size_r;

    // Working copy of the remaining byte count
    logic [31:0]         remaining_r;

    logic                reg_wr_ok_s;
    logic                start_s;
    logic                last_word_s;
    logic                unused_wdata_s;

    // Register writes are locked out for the whole transfer; a start is only
    // taken from IDLE so a write landing in DONE cannot restart the engine.
    assign reg_wr_ok_s    = reg_wr & ~dma_busy;
    assign start_s        = reg_wr_ok_s & (reg_addr == A_INIT_TRAN) & (state_r == IDLE);
    assign last_word_s    = (remaining_r == 32'd4);
    assign unused_wdata_s = ^reg_wdata[1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    if (t_size_r == 32'd0) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RD_REQ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_REQ: begin
                if (disk_rd_ack) begin
                    state_next_s = WR_REQ;
                end else begin
                    state_next_s = RD_REQ;
                end
            end
            WR_REQ: begin
                if (mem_wr_ack) begin
                    if (last_word_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RD_REQ;
                    end
                end else begin
                    state_next_s = WR_REQ;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Status and request outputs, registered from the next state so they
    // track the state register exactly and drop asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disk_rd_req <= 1'b0;
            mem_wr_req  <= 1'b0;
            dma_busy    <= 1'b0;
            dma_done    <= 1'b0;
        end else begin
            disk_rd_req <= (state_next_s == RD_REQ);
            mem_wr_req  <= (state_next_s == WR_REQ);
            dma_busy    <= (state_next_s == RD_REQ) || (state_next_s == WR_REQ);
            if (state_next_s == DONE) begin
                dma_done <= 1'b1;
            end else if (start_s) begin
                dma_done <= 1'b0;
            end else begin
                dma_done <= dma_done;
            end
        end
    end

    // CPU-programmed registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disk_addr_reg_r <= '0;
            mem_addr_reg_r  <= '0;
            t_size_r        <= 32'd0;
        end else if (reg_wr_ok_s) begin
            case (reg_addr)
                A_DISK_ADDR: disk_addr_reg_r <= {reg_wdata[DISK_AW-1:2], 2'b00};
                A_MEM_ADDR:  mem_addr_reg_r  <= {reg_wdata[ADDR_W-1:2], 2'b00};
                A_T_SIZE:    t_size_r        <= {reg_wdata[31:2], 2'b00};
                default:     t_size_r        <= t_size_r;
            endcase
        end else begin
            t_size_r <= t_size_r;
        end
    end

    // Working pointers, remaining count and data buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disk_addr   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
            remaining_r <= 32'd0;
        end else if (start_s) begin
            disk_addr   <= disk_addr_reg_r;
            mem_addr    <= mem_addr_reg_r;
            remaining_r <= t_size_r;
        end else if ((state_r == RD_REQ) && disk_rd_ack) begin
            mem_wdata   <= disk_rd_data;
        end else if ((state_r == WR_REQ) && mem_wr_ack) begin
            // Both pointers wrap naturally at their own widths
            disk_addr   <= disk_addr + DISK_STEP;
            mem_addr    <= mem_addr + MEM_STEP;
            remaining_r <= remaining_r - 32'd4;
        end else begin
            remaining_r <= remaining_r;
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rdata <= 32'd0;
        end else if (reg_rd) begin
            case (reg_addr)
                A_DISK_ADDR: reg_rdata <= 32'(disk_addr_reg_r);
                A_MEM_ADDR:  reg_rdata <= 32'(mem_addr_reg_r);
                A_T_SIZE:    reg_rdata <= t_size_r;
                A_INIT_TRAN: reg_rdata <= {30'd0, dma_busy, dma_done};
                default:     reg_rdata <= 32'd0;
            endcase
        end else begin
            reg_rdata <= reg_rdata;
        end
    end

endmodule
